branch_update_queue: RTL and testbench
======================================

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter PC_W, default 10, width of branch PC.
REQ-002 Parameter DEPTH, default 8, number of in-flight branch entries (power of 2).
REQ-003 Port clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-005 Port pred_valid  input  1  predictor issues a prediction this cycle.
REQ-006 Port pred_pc  input  PC_W  PC of the predicted branch.
REQ-007 Port pred_taken  input  1  predicted direction (1 = taken).
REQ-008 Port pred_ready  output  1  queue can accept a prediction.
REQ-009 Port res_valid  input  1  execute stage resolves the oldest in-flight branch.
REQ-010 Port res_taken  input  1  actual direction of that branch.
REQ-011 Port upd_valid  output  1  one-cycle pulse: predictor table update is valid.
REQ-012 Port upd_pc  output  PC_W  PC to train.
REQ-013 Port upd_taken  output  1  actual outcome to train with.
REQ-014 Port upd_mispredict  output  1  the resolved prediction was wrong; qualified by upd_valid.
REQ-015 Port res_err  output  1  one-cycle pulse: resolution arrived with no entry to match.
REQ-016 Port occupancy  output  log2(DEPTH)+1  number of valid entries.
REQ-017 Port br_count  output  16  resolved branches since reset.
REQ-018 Port mp_count  output  16  mispredicted branches since reset.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH entries {pc, pred_taken}, with head/tail pointers wrapping modulo DEPTH.
REQ-020 pred_ready SHALL equal (occupancy != DEPTH), derived from registered state only.
REQ-021 A push SHALL occur on an edge where pred_valid && pred_ready; pred_valid while full SHALL be dropped with no state change.
REQ-022 A resolve SHALL occur on an edge where res_valid && occupancy != 0, matching the head entry only (in-order resolution).
REQ-023 On a resolve, the next cycle SHALL show upd_valid=1, upd_pc=head pc, upd_taken=res_taken, upd_mispredict=(res_taken != head pred_taken); latency is exactly 1 cycle.
REQ-024 upd_valid, upd_mispredict and res_err SHALL be 0 in every cycle not following a resolve or error event; upd_pc/upd_taken hold their last values.
REQ-025 A correct resolve SHALL pop the head entry only (occupancy decremented by 1).
REQ-026 A mispredicted resolve SHALL flush the queue: head=tail, occupancy=0 at that same edge, discarding all younger wrong-path entries.
REQ-027 Simultaneous push and correct resolve SHALL both take effect; occupancy is unchanged.
REQ-028 Simultaneous push and mispredicted resolve SHALL discard the push; occupancy becomes 0.
REQ-029 res_valid while occupancy==0 SHALL be ignored for the FIFO and SHALL produce res_err=1 the next cycle, even if a push occurs at the same edge.
REQ-030 br_count SHALL increment by 1 per resolve, wrapping from 16'hFFFF to 0.
REQ-031 mp_count SHALL increment by 1 per mispredicted resolve, saturating at 16'hFFFF.
REQ-032 Full and empty SHALL be distinguished by occupancy, not pointer equality alone.

Reset
REQ-033 While reset=0: occupancy=0, head=tail=0, pred_ready=1, upd_valid=0, upd_mispredict=0, upd_pc=0, upd_taken=0, res_err=0, br_count=0, mp_count=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight entries and any pending update pulse asynchronously.
REQ-035 The first push SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-036 Push PC=10 taken, PC=20 taken; resolve taken twice -> upd_pc=10 then 20, upd_mispredict=0 both, br_count=2, mp_count=0, occupancy=0.
REQ-037 Push 8 entries; 9th push (PC=99) while full -> pred_ready=0, occupancy=8, PC=99 never appears on upd_pc.
REQ-038 Push PC=10 pred taken, PC=20, PC=30; resolve not-taken -> next cycle upd_pc=10, upd_taken=0, upd_mispredict=1, occupancy=0, mp_count=1.
REQ-039 Resolve with queue empty, same-cycle push PC=40 -> res_err=1 next cycle, upd_valid=0, occupancy=1, br_count unchanged.
REQ-040 Queue full, push PC=50 and correct resolve same cycle -> push still rejected (pred_ready=0), occupancy=7; then push PC=50 -> occupancy=8, head/tail wrapped correctly, PC=50 resolved in order last.
REQ-041 Assert reset low with 5 entries and resolve in flight -> occupancy=0, upd_valid=0, counters 0 immediately, before next clock edge.

Source files
------------

// File: rtl/branch_update_queue.sv
// In-order queue of in-flight branch predictions. Resolutions pop the oldest
// entry and emit a one-cycle predictor training pulse; a mispredict flushes.
module branch_update_queue #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pred_valid,
    input  logic [PC_W-1:0]          pred_pc,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [PC_W-1:0]          upd_pc,
    output logic                     upd_taken,
    output logic                     upd_mispredict,
    output logic                     res_err,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              br_count,
    output logic [15:0]              mp_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic            mem_taken [DEPTH];

    logic [AW-1:0] head, tail;
    logic [AW:0]   occ, occ_nx;
    logic          full, push, resolve, mispred, err;

    // Handshake: a prediction transfers on any rising edge where pred_valid
    // and pred_ready are both high; pred_ready depends only on registered
    // occupancy, so it never combinationally follows pred_valid.
    assign full       = (occ == FULL_OCC);
    assign pred_ready = !full;
    assign occupancy  = occ;

    assign push    = pred_valid && pred_ready;
    assign resolve = res_valid && (occ != '0);
    assign mispred = resolve && (res_taken != mem_taken[head]);
    assign err     = res_valid && (occ == '0);

    always_comb begin
        occ_nx = occ;
        if (mispred) begin
            occ_nx = '0;
        end else if (push && !resolve) begin
            occ_nx = occ + (AW+1)'(1);
        end else if (resolve && !push) begin
            occ_nx = occ - (AW+1)'(1);
        end
    end

    // Entry storage needs no reset: occupancy alone says which slots are live.
    always_ff @(posedge clock) begin
        if (push && !mispred) begin
            mem_pc[tail]    <= pred_pc;
            mem_taken[tail] <= pred_taken;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head           <= '0;
            tail           <= '0;
            occ            <= '0;
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            upd_mispredict <= 1'b0;
            res_err        <= 1'b0;
            br_count       <= '0;
            mp_count       <= '0;
        end else begin
            occ <= occ_nx;
            if (mispred) begin
                // Drop the resolved entry and every younger wrong-path entry.
                head <= head + AW'(1);
                tail <= head + AW'(1);
            end else begin
                if (push)    tail <= tail + AW'(1);
                if (resolve) head <= head + AW'(1);
            end

            upd_valid      <= resolve;
            upd_mispredict <= mispred;
            res_err        <= err;
            if (resolve) begin
                upd_pc    <= mem_pc[head];
                upd_taken <= res_taken;
                br_count  <= br_count + 16'd1;
            end
            if (mispred && (mp_count != 16'hFFFF)) begin
                mp_count <= mp_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue: a vector table for the basic
// push/resolve/flush/error flows plus sequences for full, wrap and reset.
module tb_branch_update_queue;

    localparam int PC_W  = 10;
    localparam int DEPTH = 8;

    logic            clock;
    logic            reset;
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic            pred_ready;
    logic            res_valid;
    logic            res_taken;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_mispredict;
    logic            res_err;
    logic [3:0]      occupancy;
    logic [15:0]     br_count;
    logic [15:0]     mp_count;

    branch_update_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_ready     (pred_ready),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .res_err        (res_err),
        .occupancy      (occupancy),
        .br_count       (br_count),
        .mp_count       (mp_count)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic        pv;
        logic [9:0]  pc;
        logic        pt;
        logic        rv;
        logic        rt;
        logic        e_rdy;
        logic        e_uv;
        logic [9:0]  e_upc;
        logic        e_ut;
        logic        e_ump;
        logic        e_err;
        logic [3:0]  e_occ;
        logic [15:0] e_br;
        logic [15:0] e_mp;
    } vec_t;

    vec_t vecs[13];

    int n_vec;
    int n_err;
    logic [PC_W-1:0] exp_q[$];
    logic [PC_W-1:0] exp_pc;
    logic [15:0] exp_br;
    logic [3:0]  exp_occ;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [9:0] pc, input logic pt,
                         input logic rv, input logic rt);
        pred_valid = pv;
        pred_pc    = pc;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);

        // pv pc pt rv rt | rdy uv upc ut ump err occ br mp
        vecs[0]  = '{1, 10, 1, 0, 0,  1, 0,  0, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{1, 20, 1, 0, 0,  1, 0,  0, 0, 0, 0, 2, 0, 0};
        vecs[2]  = '{0,  0, 0, 1, 1,  1, 1, 10, 1, 0, 0, 1, 1, 0};
        vecs[3]  = '{0,  0, 0, 1, 1,  1, 1, 20, 1, 0, 0, 0, 2, 0};
        vecs[4]  = '{0,  0, 0, 0, 0,  1, 0, 20, 1, 0, 0, 0, 2, 0};
        vecs[5]  = '{1, 10, 1, 0, 0,  1, 0, 20, 1, 0, 0, 1, 2, 0};
        vecs[6]  = '{1, 20, 1, 0, 0,  1, 0, 20, 1, 0, 0, 2, 2, 0};
        vecs[7]  = '{1, 30, 1, 0, 0,  1, 0, 20, 1, 0, 0, 3, 2, 0};
        vecs[8]  = '{0,  0, 0, 1, 0,  1, 1, 10, 0, 1, 0, 0, 3, 1};
        vecs[9]  = '{0,  0, 0, 0, 0,  1, 0, 10, 0, 0, 0, 0, 3, 1};
        vecs[10] = '{1, 40, 1, 1, 1,  1, 0, 10, 0, 0, 1, 1, 3, 1};
        vecs[11] = '{0,  0, 0, 1, 1,  1, 1, 40, 1, 0, 0, 0, 4, 1};
        vecs[12] = '{0,  0, 0, 0, 0,  1, 0, 40, 1, 0, 0, 0, 4, 1};

        #12;
        chk("rst occupancy", 32'(occupancy), 0);
        chk("rst pred_ready", 32'(pred_ready), 1);
        chk("rst upd_valid", 32'(upd_valid), 0);
        chk("rst upd_pc", 32'(upd_pc), 0);
        chk("rst res_err", 32'(res_err), 0);
        chk("rst br_count", 32'(br_count), 0);
        chk("rst mp_count", 32'(mp_count), 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].pv, vecs[i].pc, vecs[i].pt, vecs[i].rv, vecs[i].rt);
            step();
            chk($sformatf("v%0d pred_ready", i), 32'(pred_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d upd_valid", i), 32'(upd_valid), 32'(vecs[i].e_uv));
            chk($sformatf("v%0d upd_pc", i), 32'(upd_pc), 32'(vecs[i].e_upc));
            chk($sformatf("v%0d upd_taken", i), 32'(upd_taken), 32'(vecs[i].e_ut));
            chk($sformatf("v%0d upd_mispredict", i), 32'(upd_mispredict), 32'(vecs[i].e_ump));
            chk($sformatf("v%0d res_err", i), 32'(res_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(vecs[i].e_occ));
            chk($sformatf("v%0d br_count", i), 32'(br_count), 32'(vecs[i].e_br));
            chk($sformatf("v%0d mp_count", i), 32'(mp_count), 32'(vecs[i].e_mp));
        end

        // Fill to full, reject overflow, then drain across the pointer wrap.
        exp_br  = 16'd4;
        exp_occ = 4'd0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 10'(100 + i), 1, 0, 0);
            step();
            exp_occ++;
            exp_q.push_back(10'(100 + i));
            chk("fill occupancy", 32'(occupancy), 32'(exp_occ));
        end
        drive(1, 99, 1, 0, 0);
        chk("full pred_ready", 32'(pred_ready), 0);
        step();
        chk("overflow occupancy", 32'(occupancy), 8);

        drive(1, 50, 1, 1, 1);
        chk("full+res pred_ready", 32'(pred_ready), 0);
        step();
        exp_pc = exp_q.pop_front();
        exp_br++;
        chk("full+res upd_valid", 32'(upd_valid), 1);
        chk("full+res upd_pc", 32'(upd_pc), 32'(exp_pc));
        chk("full+res occupancy", 32'(occupancy), 7);

        drive(1, 50, 1, 0, 0);
        step();
        exp_q.push_back(10'd50);
        chk("refill occupancy", 32'(occupancy), 8);

        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step();
            exp_pc = exp_q.pop_front();
            exp_br++;
            chk("drain upd_valid", 32'(upd_valid), 1);
            chk("drain upd_pc", 32'(upd_pc), 32'(exp_pc));
            chk("drain upd_mispredict", 32'(upd_mispredict), 0);
            chk("drain br_count", 32'(br_count), 32'(exp_br));
        end
        drive(0, 0, 0, 0, 0);
        step();
        chk("drained occupancy", 32'(occupancy), 0);
        chk("drained upd_valid", 32'(upd_valid), 0);
        chk("drained mp_count", 32'(mp_count), 1);

        // Asynchronous reset with entries and a pending update in flight.
        for (int i = 0; i < 5; i++) begin
            drive(1, 10'(200 + i), 1, 0, 0);
            step();
        end
        drive(0, 0, 0, 1, 1);
        step();
        chk("pre-reset upd_valid", 32'(upd_valid), 1);
        chk("pre-reset occupancy", 32'(occupancy), 4);
        #1 reset = 1'b0;
        #1;
        chk("async rst occupancy", 32'(occupancy), 0);
        chk("async rst upd_valid", 32'(upd_valid), 0);
        chk("async rst upd_pc", 32'(upd_pc), 0);
        chk("async rst br_count", 32'(br_count), 0);
        chk("async rst mp_count", 32'(mp_count), 0);
        chk("async rst pred_ready", 32'(pred_ready), 1);
        drive(0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        drive(1, 300, 0, 0, 0);
        step();
        chk("first push occupancy", 32'(occupancy), 1);
        drive(0, 0, 0, 1, 0);
        step();
        chk("post-rst upd_pc", 32'(upd_pc), 300);
        chk("post-rst upd_mispredict", 32'(upd_mispredict), 0);
        chk("post-rst br_count", 32'(br_count), 1);
        drive(0, 0, 0, 0, 0);
        step();

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
